// File: rtl/console_usb_dev.sv
// Device-side command responder for the ADC link: consumes one received packet,
// runs the ADC configure or convert handshake, then queues a single reply packet.
module console_usb_dev #(
  parameter logic [15:0] ADC_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_read,
  output logic        fd_read,
  input  logic [3:0]  read_btype,
  input  logic [15:0] cmd_data,
  output logic        fs_send,
  input  logic        fd_send,
  output logic [3:0]  send_btype,
  output logic [15:0] reply_data,
  output logic        fs_conf,
  input  logic        fd_conf,
  output logic        fs_conv,
  input  logic        fd_conv,
  output logic [15:0] adc_conf,
  input  logic [7:0]  dev_temp,
  input  logic [7:0]  dev_type
);

  localparam logic [3:0] PKT_INIT   = 4'b0000;
  localparam logic [3:0] PKT_NAK    = 4'b0010;
  localparam logic [3:0] PKT_STL    = 4'b0011;
  localparam logic [3:0] PKT_DIDX   = 4'b0101;
  localparam logic [3:0] PKT_DPARAM = 4'b0110;
  localparam logic [3:0] PKT_DTEMP  = 4'b1010;
  localparam logic [3:0] PKT_DATA0  = 4'b1101;
  localparam logic [3:0] PKT_DATA1  = 4'b1110;
  localparam logic [3:0] PKT_ERROR  = 4'b1111;

  localparam logic [7:0] MAIN_IDLE = 8'h00;
  localparam logic [7:0] MAIN_WAIT = 8'h01;
  localparam logic [7:0] READ_TAKE = 8'h02;
  localparam logic [7:0] READ_DONE = 8'h03;
  localparam logic [7:0] CONF_WORK = 8'h11;
  localparam logic [7:0] CONV_WORK = 8'h21;
  localparam logic [7:0] SEND_WORK = 8'h31;
  localparam logic [7:0] SEND_DONE = 8'h32;

  localparam logic [15:0] TCNT_LAST = ADC_TIMEOUT - 16'd1;

  logic [7:0]  state;
  logic [3:0]  cmd_type;
  logic [15:0] cmd_word;
  logic [15:0] tcnt;
  logic        toggle;
  logic        conf_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MAIN_IDLE;
      cmd_type   <= PKT_INIT;
      cmd_word   <= 16'h0000;
      send_btype <= PKT_INIT;
      reply_data <= 16'h0000;
      adc_conf   <= 16'h0000;
      tcnt       <= 16'h0000;
      toggle     <= 1'b0;
      conf_valid <= 1'b0;
    end else begin
      case (state)
        MAIN_IDLE: state <= MAIN_WAIT;
        MAIN_WAIT: if (fs_read) state <= READ_TAKE;
        READ_TAKE: begin
          cmd_type <= read_btype;
          cmd_word <= cmd_data;
          state    <= READ_DONE;
        end
        READ_DONE: begin
          if (!fs_read) begin
            tcnt <= 16'h0000;
            if (cmd_type == PKT_DPARAM) begin
              adc_conf   <= cmd_word;
              conf_valid <= 1'b1;
              state      <= CONF_WORK;
            end else if (cmd_type == PKT_DIDX && conf_valid) begin
              state <= CONV_WORK;
            end else begin
              send_btype <= (cmd_type == PKT_DIDX) ? PKT_NAK : PKT_STL;
              reply_data <= 16'h0000;
              state      <= SEND_WORK;
            end
          end
        end
        CONF_WORK: begin
          tcnt <= tcnt + 16'd1;
          if (fd_conf) begin
            send_btype <= PKT_DTEMP;
            reply_data <= {dev_temp, dev_type};
            toggle     <= 1'b0;
            state      <= SEND_WORK;
          end else if (tcnt == TCNT_LAST) begin
            send_btype <= PKT_ERROR;
            reply_data <= 16'hFFFF;
            state      <= SEND_WORK;
          end
        end
        CONV_WORK: begin
          tcnt <= tcnt + 16'd1;
          // Done on the last allowed cycle still counts as success.
          if (fd_conv) begin
            send_btype <= toggle ? PKT_DATA1 : PKT_DATA0;
            reply_data <= 16'h0000;
            toggle     <= ~toggle;
            state      <= SEND_WORK;
          end else if (tcnt == TCNT_LAST) begin
            send_btype <= PKT_ERROR;
            reply_data <= 16'hFFFF;
            state      <= SEND_WORK;
          end
        end
        SEND_WORK: if (fd_send) state <= SEND_DONE;
        SEND_DONE: if (!fd_send) state <= MAIN_WAIT;
        default:   state <= MAIN_IDLE;
      endcase
    end
  end

  assign fd_read = (state == READ_DONE);
  assign fs_conf = (state == CONF_WORK);
  assign fs_conv = (state == CONV_WORK);
  assign fs_send = (state == SEND_WORK);

endmodule

// File: tb/tb_console_usb_dev.sv
// Scoreboard bench for console_usb_dev: stimulus pushes expected replies,
// a transmitter-side monitor pops and compares each presented reply.
module tb_console_usb_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs_read = 1'b0;
  logic        fd_read;
  logic [3:0]  read_btype = 4'b0000;
  logic [15:0] cmd_data = 16'h0000;
  logic        fs_send;
  logic        fd_send = 1'b0;
  logic [3:0]  send_btype;
  logic [15:0] reply_data;
  logic        fs_conf;
  logic        fd_conf = 1'b0;
  logic        fs_conv;
  logic        fd_conv = 1'b0;
  logic [15:0] adc_conf;
  logic [7:0]  dev_temp = 8'h00;
  logic [7:0]  dev_type = 8'h55;

  int checks = 0;
  int errors = 0;
  int replies_seen = 0;
  int conf_cycles = 0;
  int conv_cycles = 0;
  int conf_wait = 0;
  int conv_wait = 0;
  int adc_delay = 5;
  bit conv_hold_low = 1'b0;

  logic [19:0] exp_q[$];

  console_usb_dev #(.ADC_TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst),
    .fs_read(fs_read), .fd_read(fd_read),
    .read_btype(read_btype), .cmd_data(cmd_data),
    .fs_send(fs_send), .fd_send(fd_send),
    .send_btype(send_btype), .reply_data(reply_data),
    .fs_conf(fs_conf), .fd_conf(fd_conf),
    .fs_conv(fs_conv), .fd_conv(fd_conv),
    .adc_conf(adc_conf),
    .dev_temp(dev_temp), .dev_type(dev_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ADC controller model: raise done after adc_delay request cycles
  initial forever begin
    @(negedge clk);
    if (fs_conf) begin
      conf_cycles++;
      conf_wait++;
      if (conf_wait >= adc_delay) fd_conf = 1'b1;
    end else begin
      conf_wait = 0;
      fd_conf = 1'b0;
    end
    if (fs_conv) begin
      conv_cycles++;
      conv_wait++;
      if (conv_wait >= adc_delay && !conv_hold_low) fd_conv = 1'b1;
    end else begin
      conv_wait = 0;
      fd_conv = 1'b0;
    end
  end

  // Transmitter model and scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (fs_send && !fd_send) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reply actual=%b/%h required=none", send_btype, reply_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("reply_btype", {28'd0, send_btype}, {28'd0, e[19:16]});
        check("reply_data", {16'd0, reply_data}, {16'd0, e[15:0]});
      end
      replies_seen++;
      fd_send = 1'b1;
    end else if (!fs_send && fd_send) begin
      fd_send = 1'b0;
    end
  end

  task automatic send_pkt(input logic [3:0] bt, input logic [15:0] d,
                          input logic [3:0] exp_bt, input logic [15:0] exp_d);
    int n;
    int start;
    start = replies_seen;
    exp_q.push_back({exp_bt, exp_d});
    @(negedge clk);
    read_btype = bt;
    cmd_data   = d;
    fs_read    = 1'b1;
    n = 0;
    while (!fd_read && n < 100) begin @(negedge clk); n++; end
    if (!fd_read) begin
      checks++; errors++;
      $display("FAIL fd_read_timeout actual=0 required=1");
    end
    fs_read = 1'b0;
    n = 0;
    while (replies_seen == start && n < 200) begin @(negedge clk); n++; end
    if (replies_seen == start) begin
      checks++; errors++;
      $display("FAIL reply_timeout actual=none required=%b", exp_bt);
    end
    n = 0;
    while ((fs_send || fd_send) && n < 50) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_fs_outputs", {28'd0, fd_read, fs_send, fs_conf, fs_conv}, 32'd0);
    check("reset_send_btype", {28'd0, send_btype}, 32'd0);
    check("reset_reply_data", {16'd0, reply_data}, 32'd0);
    check("reset_adc_conf", {16'd0, adc_conf}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    conv_cycles = 0;
    send_pkt(4'b0101, 16'h0000, 4'b0010, 16'h0000);
    check("nak_no_conv", conv_cycles, 0);

    conf_cycles = 0;
    send_pkt(4'b0001, 16'h0000, 4'b0011, 16'h0000);
    check("stl_no_conf_conv", conf_cycles + conv_cycles, 0);

    dev_temp = 8'h2A; dev_type = 8'h55;
    conf_cycles = 0;
    send_pkt(4'b0110, 16'h1234, 4'b1010, 16'h2A55);
    check("adc_conf_1", {16'd0, adc_conf}, 32'h1234);
    check("conf_cycles_1", conf_cycles, 5);

    send_pkt(4'b0101, 16'h0000, 4'b1101, 16'h0000);
    send_pkt(4'b0101, 16'h0000, 4'b1110, 16'h0000);
    send_pkt(4'b0101, 16'h0000, 4'b1101, 16'h0000);

    dev_temp = 8'h31; dev_type = 8'hAA;
    send_pkt(4'b0110, 16'hBEEF, 4'b1010, 16'h31AA);
    check("adc_conf_2", {16'd0, adc_conf}, 32'hBEEF);
    send_pkt(4'b0101, 16'h0000, 4'b1101, 16'h0000);

    conv_hold_low = 1'b1;
    conv_cycles = 0;
    send_pkt(4'b0101, 16'h0000, 4'b1111, 16'hFFFF);
    check("timeout_conv_cycles", conv_cycles, 16);
    conv_hold_low = 1'b0;
    send_pkt(4'b0101, 16'h0000, 4'b1110, 16'h0000);

    // reset pulsed while a conversion is pending
    conv_hold_low = 1'b1;
    @(negedge clk);
    read_btype = 4'b0101;
    fs_read = 1'b1;
    n = 0;
    while (!fd_read && n < 100) begin @(negedge clk); n++; end
    fs_read = 1'b0;
    n = 0;
    while (!fs_conv && n < 100) begin @(negedge clk); n++; end
    check("conv_started", {31'd0, fs_conv}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_fs_conv", {31'd0, fs_conv}, 32'd0);
    check("rst_send_btype", {28'd0, send_btype}, 32'd0);
    check("rst_adc_conf", {16'd0, adc_conf}, 32'd0);
    conv_hold_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    conv_cycles = 0;
    send_pkt(4'b0101, 16'h0000, 4'b0010, 16'h0000);
    check("post_rst_nak_no_conv", conv_cycles, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_usb_dev.md
# console_usb_dev

Device-side command responder for the ADC link; it is the counterpart of the host console that broadcasts DPARAM/DIDX packets and collects DTEMP/DATA0/DATA1 replies. It sits between the link receiver, the link transmitter and the local ADC controller. It takes one received packet and runs the matching ADC configure or convert operation. It then queues exactly one reply packet and returns to idle.

## Interface
- ADC_TIMEOUT, 16'd50000: maximum cycles spent waiting for fd_conf/fd_conv before an error reply.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- fs_read  input  1  receiver has a packet; held high until fd_read is seen.
- fd_read  output  1  packet consumed; high in READ_DONE only.
- read_btype  input  4  received packet type; valid while fs_read is high.
- cmd_data  input  16  received parameter word; valid while fs_read is high.
- fs_send  output  1  reply ready for the transmitter; high in *_SEND states.
- fd_send  input  1  transmitter done; level signal.
- send_btype  output  4  reply packet type (registered).
- reply_data  output  16  reply payload (registered).
- fs_conf / fd_conf  output / input  1  ADC configure request / done.
- fs_conv / fd_conv  output / input  1  ADC convert request / done.
- adc_conf  output  16  latched configuration word, feeds the ADC controller.
- dev_temp  input  8  local temperature.
- dev_type  input  8  device type code: 8'h55, 8'hAA or 8'hFF.

## Operation
- Packet codes: INIT 0000, ACK 0001, NAK 0010, STL 0011, DIDX 0101, DPARAM 0110, DTEMP 1010, DATA0 1101, DATA1 1110, ERROR 1111.
- State codes (8 bit): MAIN_IDLE 00, MAIN_WAIT 01, READ_TAKE 02, READ_DONE 03, CONF_WORK 11, CONV_WORK 21, SEND_WORK 31, SEND_DONE 32.
- MAIN_IDLE -> MAIN_WAIT unconditionally.
- MAIN_WAIT -> READ_TAKE when fs_read=1. READ_TAKE latches read_btype into cmd_type and cmd_data into cmd_word, then goes to READ_DONE.
- READ_DONE: fd_read=1; stays until fs_read=0.
- Decode on leaving READ_DONE:
  - DPARAM: adc_conf <= cmd_word; conf_valid <= 1; go to CONF_WORK.
  - DIDX with conf_valid=1: go to CONV_WORK.
  - DIDX with conf_valid=0: send_btype <= NAK, reply_data <= 0; go to SEND_WORK.
  - Any other type: send_btype <= STL, reply_data <= 0; go to SEND_WORK.
- CONF_WORK: fs_conf=1.
  - On fd_conf=1: send_btype <= DTEMP; reply_data <= {dev_temp, dev_type} sampled that cycle; data toggle <= 0; go to SEND_WORK.
- CONV_WORK: fs_conv=1.
  - On fd_conv=1: send_btype <= toggle ? DATA1 : DATA0; reply_data <= 0; toggle inverts; go to SEND_WORK.
- Timeout: tcnt clears on entry to CONF_WORK/CONV_WORK and increments each cycle there. When tcnt == ADC_TIMEOUT-1 and the done input is still low: send_btype <= ERROR, reply_data <= 16'hFFFF; go to SEND_WORK. The toggle is not changed. If done arrives on that same cycle, done wins.
- SEND_WORK: fs_send=1; go to SEND_DONE when fd_send=1.
- SEND_DONE: fs_send=0; go to MAIN_WAIT when fd_send=0.
- fs_read arriving in any state other than MAIN_WAIT is ignored until MAIN_WAIT is reached.
- conf_valid is cleared only by reset. The first DATA reply after every DPARAM is DATA0, matching the host's DTEMP -> DATA0 -> DATA1 sequence.

## Timing
- Reset values:
  - state MAIN_IDLE.
  - fd_read, fs_send, fs_conf, fs_conv = 0.
  - send_btype = INIT, reply_data = 0, adc_conf = 0.
  - toggle = 0, conf_valid = 0, tcnt = 0.
- All handshakes are four-phase level: each request stays high until its done is seen.
- fs_read first sampled high at edge N gives fd_read high from edge N+2. fd_read falls the cycle after fs_read is sampled low.
- fd_conf/fd_conv sampled high at edge M gives: fs_conf/fs_conv low and fs_send high from edge M+1. send_btype and reply_data are stable from edge M+1 until the next reply.
- fs_* and fd_read are decoded combinationally from state. No output glitches within one state.
- Reset asserted mid-operation returns all outputs to reset values immediately. adc_conf and conf_valid are lost.

## Test plan
- Reset, then DPARAM with cmd_data=16'h1234, fd_conf after 5 cycles, dev_temp=8'h2A, dev_type=8'h55 -> adc_conf=16'h1234, send_btype=1010, reply_data=16'h2A55, one fs_send pulse completed.
- DPARAM then three DIDX packets -> replies DATA0, DATA1, DATA0. A second DPARAM followed by DIDX -> DATA0.
- DIDX straight after reset -> NAK reply, fs_conv never asserted.
- read_btype=0001 -> STL reply, no fs_conf/fs_conv.
- DIDX with fd_conv held low, ADC_TIMEOUT=16 -> fs_conv high exactly 16 cycles, then ERROR reply with reply_data=16'hFFFF. The next DIDX still returns the un-advanced DATA type.
- rst pulsed during CONV_WORK -> fs_conv=0, send_btype=INIT, adc_conf=0 at once; a subsequent DIDX gets NAK.
